alu_reservation_station: RTL
============================

// Module: alu_reservation_station
// PURPOSE
//   Age-ordered reservation station sitting between dispatch and one execution unit (ALU).
//   Holds dispatched instructions until both source operands are available.
//   Captures missing operands by snooping the CDB (tag match).
//   Issues the oldest ready entry to the unit over a valid/ready request handshake.
// PARAMETERS
//   RS_DEPTH    4           number of entries, >=2
//   DATA_WIDTH  32          operand / CDB data width
//   ROB_W       ROB_WIDTH   ROB tag width (from common.vh)
//   INST_W      INST_WIDTH  instruction word width (from common.vh)
// PORTS
//   clk            in   1                     clock, all state on rising edge
//   reset          in   1                     asynchronous, active-high; clears all entries
//   flush          in   1                     mispredict squash; discards every entry
//   disp_valid     in   1                     dispatch request
//   disp_ready     out  1                     station can accept (count < RS_DEPTH)
//   disp_inst      in   INST_W                instruction bits
//   disp_tag       in   ROB_W                 destination ROB tag (new_tag)
//   disp_op_valid  in   2                     [i]=1: operand i data present
//   disp_op_tag    in   2*ROB_W               producer tag per operand ([ROB_W-1:0]=op0)
//   disp_op_data   in   2*DATA_WIDTH          operand data ([DATA_WIDTH-1:0]=op0)
//   cdb_valid      in   1                     CDB broadcast valid
//   cdb_tag        in   ROB_W                 CDB tag
//   cdb_data       in   DATA_WIDTH            CDB data
//   issue_valid    out  1                     ready entry presented to unit
//   issue_ready    in   1                     unit accepts this cycle
//   issue_inst     out  INST_W                issued instruction
//   issue_tag      out  ROB_W                 issued destination tag
//   issue_op0      out  DATA_WIDTH            operand 0
//   issue_op1      out  DATA_WIDTH            operand 1
//   count          out  $clog2(RS_DEPTH+1)    occupied entries
// BEHAVIOUR
//   Reset (async): count=0, all entry valid bits 0 -> issue_valid=0, disp_ready=1.
//     Reset may assert at any cycle; an in-flight dispatch or issue is lost.
//   Storage: collapsing queue; slot 0 is oldest; slots [0,count) are valid.
//   Handshakes: dispatch fires on disp_valid&&disp_ready; issue fires on issue_valid&&issue_ready.
//   disp_ready = (count<RS_DEPTH), from registered state only.
//     A same-cycle issue never frees room for a dispatch when full.
//   Dispatch write: the new entry goes to slot count, or to slot count-1 if an issue fires in the same cycle.
//     Per operand: stored ready if disp_op_valid[i].
//     Also stored ready if cdb_valid && cdb_tag==disp_op_tag[i]; cdb_data is captured (same-cycle bypass).
//   Wakeup: every valid entry whose operand i is not ready, with cdb_valid && cdb_tag==its tag,
//     stores cdb_data and sets ready at the edge.
//     Both operands may match the same broadcast.
//   Issue select: oldest valid entry with both operands ready, using registered state only.
//     Latency: CDB broadcast at cycle t -> entry eligible at t+1.
//     Latency: dispatch at t with both operands ready -> eligible at t+1.
//   Issue outputs are combinational from the selected slot.
//     The payload may change while issue_ready=0 (e.g. an older entry becomes ready).
//     The unit samples the payload only on the fire cycle.
//   On issue fire: the selected entry is removed; younger entries shift down one slot, preserving age order.
//     CDB capture applies to each entry at its post-shift position in the same edge.
//   count_next = count + dispatch_fire - issue_fire; never exceeds RS_DEPTH or wraps below 0.
//   Flush: while flush=1, issue_valid=0 and disp_ready=0.
//     At the edge count=0 and all entries are cleared; dispatch/CDB/issue that cycle are ignored.
//     Flush overrides all other events.
//   Empty: issue_valid=0; issue_* data outputs are don't-care.
// TESTING
//   1. Assert reset mid-run with 3 entries -> same cycle issue_valid=0, count=0, disp_ready=1.
//   2. Dispatch tag=3, ops ready 5/7, issue_ready=1 -> next cycle issue_valid=1, tag=3, op0=5, op1=7; count 1->0.
//   3. Dispatch tag=4, op1 waiting on tag 9; next cycle CDB tag 9 data 0x1234
//      -> issue_valid on the following cycle with op1=0x1234.
//   4. Dispatch op0 waiting on tag 2 while CDB broadcasts tag 2 data 0xAA the same cycle
//      -> entry issues next cycle with op0=0xAA.
//   5. Fill 4 entries (tags 1..4, all ready) with issue_ready=0 -> disp_ready=0.
//      Then issue_ready=1 -> issues tags 1,2,3,4 in order.
//      Issue + dispatch in the same cycle when count=3 -> count stays 3.
//   6. 3 entries held, assert flush with disp_valid=1 and a matching CDB -> issue_valid=0 that cycle.
//      Next cycle count=0 and no entry ever issues.

Source files
------------

// File: rtl/alu_reservation_station_if.sv
// alu_reservation_station_if
//   Bundles the ALU reservation station's dispatch, CDB snoop and issue
//   signals. clk and reset stay plain ports on the station itself.
//   Modports:
//     slave  - the reservation station (takes dispatch/CDB/issue_ready/flush,
//              drives disp_ready, issue payload and count)
//     master - the environment around it (dispatch stage, CDB, execution unit)
interface alu_reservation_station_if #(
  parameter int RS_DEPTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_W      = 6,
  parameter int INST_W     = 32
);
  logic                            flush;

  logic                            disp_valid;
  logic                            disp_ready;
  logic [INST_W-1:0]               disp_inst;
  logic [ROB_W-1:0]                disp_tag;
  logic [1:0]                      disp_op_valid;
  logic [2*ROB_W-1:0]              disp_op_tag;
  logic [2*DATA_WIDTH-1:0]         disp_op_data;

  logic                            cdb_valid;
  logic [ROB_W-1:0]                cdb_tag;
  logic [DATA_WIDTH-1:0]           cdb_data;

  logic                            issue_valid;
  logic                            issue_ready;
  logic [INST_W-1:0]               issue_inst;
  logic [ROB_W-1:0]                issue_tag;
  logic [DATA_WIDTH-1:0]           issue_op0;
  logic [DATA_WIDTH-1:0]           issue_op1;

  logic [$clog2(RS_DEPTH+1)-1:0]   count;

  modport slave (
    input  flush,
    input  disp_valid, disp_inst, disp_tag, disp_op_valid, disp_op_tag, disp_op_data,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output issue_valid, issue_inst, issue_tag, issue_op0, issue_op1,
    input  issue_ready,
    output count
  );

  modport master (
    output flush,
    output disp_valid, disp_inst, disp_tag, disp_op_valid, disp_op_tag, disp_op_data,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  issue_valid, issue_inst, issue_tag, issue_op0, issue_op1,
    output issue_ready,
    input  count
  );
endinterface

// File: rtl/alu_reservation_station.sv
// alu_reservation_station
//   Age-ordered reservation station in front of a single ALU. Entries wait
//   until both source operands are present (captured by CDB tag snooping) and
//   the oldest ready entry is offered to the unit over a valid/ready handshake.
//   Ports:
//     clk    - clock, all state updates on the rising edge
//     reset  - asynchronous, active-high; empties the station
//     bus    - alu_reservation_station_if.slave: flush, dispatch, CDB, issue, count
module alu_reservation_station #(
  parameter int RS_DEPTH   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_W      = 6,
  parameter int INST_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  alu_reservation_station_if.slave   bus
);
  localparam int CW = $clog2(RS_DEPTH+1);
  localparam int IW = $clog2(RS_DEPTH);

  // Collapsing queue: slot 0 is oldest, slots [0,count_q) hold live entries.
  logic [CW-1:0]         count_q, n_count;
  logic [INST_W-1:0]     inst_q [RS_DEPTH];
  logic [ROB_W-1:0]      tag_q  [RS_DEPTH];
  logic [1:0]            rdy_q  [RS_DEPTH];
  logic [ROB_W-1:0]      otag_q [RS_DEPTH][2];
  logic [DATA_WIDTH-1:0] data_q [RS_DEPTH][2];

  logic [INST_W-1:0]     n_inst [RS_DEPTH];
  logic [ROB_W-1:0]      n_tag  [RS_DEPTH];
  logic [1:0]            n_rdy  [RS_DEPTH];
  logic [ROB_W-1:0]      n_otag [RS_DEPTH][2];
  logic [DATA_WIDTH-1:0] n_data [RS_DEPTH][2];

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          issue_valid_w, disp_ready_w;
  logic          issue_fire, disp_fire;
  logic [CW-1:0] wr_idx;

  // Oldest live entry with both operands ready; scanning from the young end
  // lets the last hit win, which is the oldest one.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (i < int'(count_q) && rdy_q[i] == 2'b11) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign disp_ready_w  = !bus.flush && (count_q < CW'(RS_DEPTH));
  assign issue_valid_w = !bus.flush && sel_found;
  assign issue_fire    = issue_valid_w && bus.issue_ready;
  assign disp_fire     = bus.disp_valid && disp_ready_w;
  // When an issue fires the queue collapses by one, so the new entry lands
  // one slot lower than the current tail.
  assign wr_idx        = count_q - CW'(issue_fire);

  assign bus.disp_ready  = disp_ready_w;
  assign bus.issue_valid = issue_valid_w;
  assign bus.issue_inst  = inst_q[sel_idx];
  assign bus.issue_tag   = tag_q[sel_idx];
  assign bus.issue_op0   = data_q[sel_idx][0];
  assign bus.issue_op1   = data_q[sel_idx][1];
  assign bus.count       = count_q;

  always_comb begin
    n_inst  = inst_q;
    n_tag   = tag_q;
    n_rdy   = rdy_q;
    n_otag  = otag_q;
    n_data  = data_q;
    n_count = count_q + CW'(disp_fire) - CW'(issue_fire);

    // Collapse over the issued slot.
    for (int j = 0; j < RS_DEPTH-1; j++) begin
      if (issue_fire && j >= int'(sel_idx)) begin
        n_inst[j] = inst_q[j+1];
        n_tag[j]  = tag_q[j+1];
        n_rdy[j]  = rdy_q[j+1];
        n_otag[j] = otag_q[j+1];
        n_data[j] = data_q[j+1];
      end
    end

    // CDB wakeup applied at the post-shift position.
    for (int j = 0; j < RS_DEPTH; j++) begin
      for (int k = 0; k < 2; k++) begin
        if (!n_rdy[j][k] && bus.cdb_valid && bus.cdb_tag == n_otag[j][k]) begin
          n_rdy[j][k]  = 1'b1;
          n_data[j][k] = bus.cdb_data;
        end
      end
    end

    // New entry, with same-cycle CDB bypass for missing operands.
    for (int j = 0; j < RS_DEPTH; j++) begin
      if (disp_fire && j == int'(wr_idx)) begin
        n_inst[j] = bus.disp_inst;
        n_tag[j]  = bus.disp_tag;
        for (int k = 0; k < 2; k++) begin
          n_otag[j][k] = bus.disp_op_tag[k*ROB_W +: ROB_W];
          if (bus.disp_op_valid[k]) begin
            n_rdy[j][k]  = 1'b1;
            n_data[j][k] = bus.disp_op_data[k*DATA_WIDTH +: DATA_WIDTH];
          end else if (bus.cdb_valid && bus.cdb_tag == bus.disp_op_tag[k*ROB_W +: ROB_W]) begin
            n_rdy[j][k]  = 1'b1;
            n_data[j][k] = bus.cdb_data;
          end else begin
            n_rdy[j][k]  = 1'b0;
            n_data[j][k] = bus.disp_op_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        inst_q[j] <= '0;
        tag_q[j]  <= '0;
        rdy_q[j]  <= '0;
        for (int k = 0; k < 2; k++) begin
          otag_q[j][k] <= '0;
          data_q[j][k] <= '0;
        end
      end
    end else if (bus.flush) begin
      // Squash overrides any dispatch, wakeup or issue seen this cycle.
      count_q <= '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        rdy_q[j] <= '0;
      end
    end else begin
      count_q <= n_count;
      inst_q  <= n_inst;
      tag_q   <= n_tag;
      rdy_q   <= n_rdy;
      otag_q  <= n_otag;
      data_q  <= n_data;
    end
  end
endmodule
